// File: rtl/simple_result_buffer.sv
// Writeback-side result FIFO with stop/drain/halt tracking and saturating result/drop counters.
// Optional RESULT_BUF_CYCLE_STAMP_EN adds a per-entry 16-bit push-cycle stamp on rd_stamp_o.
module simple_result_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [DATA_W-1:0]        result_i,
    input  logic                     result_valid_i,
    input  logic                     stop_i,
    input  logic                     rd_ready_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         result_count_o,
    output logic [CNT_W-1:0]         drop_count_o,
    output logic                     halted_o
`ifdef RESULT_BUF_CYCLE_STAMP_EN
    ,
    output logic [15:0]              rd_stamp_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_result_count;
    logic [CNT_W-1:0]   r_drop_count;
    logic               r_halted;

    logic w_full;
    logic w_rd_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_rd_valid = (r_level != '0);
    assign w_pop      = w_rd_valid && rd_ready_i;
    assign w_push     = result_valid_i && (r_state == ST_RUN) && (!w_full || w_pop);
    assign w_drop     = result_valid_i && (r_state == ST_RUN) && w_full && !w_pop;

    // Storage is not cleared by reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (n_reset && w_push) begin
            r_mem[r_wr_ptr] <= result_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state        <= ST_RUN;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_overflow     <= 1'b0;
            r_result_count <= '0;
            r_drop_count   <= '0;
            r_halted       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end

            if (w_push && (r_result_count != CNT_MAX)) begin
                r_result_count <= r_result_count + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != CNT_MAX) begin
                    r_drop_count <= r_drop_count + CNT_W'(1);
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (stop_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((r_level == '0) || ((r_level == LW'(1)) && w_pop)) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef RESULT_BUF_CYCLE_STAMP_EN
    logic [15:0] r_cycle;
    logic [15:0] r_stamp_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 16'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (n_reset && w_push) begin
            r_stamp_mem[r_wr_ptr] <= r_cycle;
        end
    end

    assign rd_stamp_o = r_stamp_mem[r_rd_ptr];
`endif

    assign rd_data_o      = r_mem[r_rd_ptr];
    assign rd_valid_o     = w_rd_valid;
    assign level_o        = r_level;
    assign full_o         = w_full;
    assign overflow_o     = r_overflow;
    assign result_count_o = r_result_count;
    assign drop_count_o   = r_drop_count;
    assign halted_o       = r_halted;

endmodule
